bw_io_ic_filter_ctl: RTL and testbench
======================================

# bw_io_ic_filter_ctl

Digital deglitch controller for the IO-cell receiver path. It sits behind the pad input filter and synchronizes its asynchronous `torcvr` output into the core clock domain. It then qualifies each level change against a programmable stability count and presents a clean level plus rise/fall pulses to core logic. Output is gated off until the IO supply reports power-good.

## Interface
- `FILT_W`, default 8: width of the stability-count input and the internal counter.
- `GLITCH_W`, default 8: width of the glitch counter.
- `RESET_VAL`, default 1'b0: level driven on `rcv_out` during reset and power-down.
- `clk`  in  1  core clock; the only clock.
- `rst_l`  in  1  reset, synchronous, active-low.
- `torcvr`  in  1  asynchronous receiver level from the pad filter.
- `vddo_pwrok`  in  1  asynchronous IO-supply power-good.
- `filt_en`  in  1  1 = filter active, 0 = bypass.
- `filt_cnt`  in  FILT_W  consecutive synchronized samples required to accept a change; 0 is treated as 1.
- `rcv_out`  out  1  filtered level.
- `rcv_rise`  out  1  one-cycle pulse when `rcv_out` goes 0→1.
- `rcv_fall`  out  1  one-cycle pulse when `rcv_out` goes 1→0.
- `filt_busy`  out  1  high while a candidate change is being qualified.
- `glitch_clr`  in  1  (macro only) clear the glitch counter.
- `glitch_cnt`  out  GLITCH_W  (macro only) count of rejected glitches.

## Operation
- `torcvr` and `vddo_pwrok` each pass through a 2-flop synchronizer. The synchronized values are `rx_s` and `pwr_s`.
  - Synchronizer flops reset to `RESET_VAL` and 0 respectively.
- FSM states: PWR_WAIT, STABLE, CHECK. Reset state is PWR_WAIT.
- **PWR_WAIT**
  - `rcv_out`=`RESET_VAL`, no pulses, counter 0.
  - When `pwr_s`=1: go to STABLE and load `rcv_out`←`rx_s`. This load produces no edge pulse.
- **STABLE**
  - `rx_s`==`rcv_out`: no action.
  - On mismatch with `filt_en`=0 or effective `filt_cnt`≤1: accept, meaning update `rcv_out` and pulse.
  - Otherwise go to CHECK with cnt←1.
- **CHECK**
  - `rx_s`==`rcv_out`: glitch. Return to STABLE, cnt←0, and increment the glitch counter.
  - Mismatch with cnt+1 ≥ `filt_cnt`: accept, return to STABLE, cnt←0.
  - Mismatch otherwise: cnt←cnt+1.
  - `filt_busy` = (state==CHECK).
- `filt_cnt` is compared live every cycle. The ≥ comparison guarantees termination if it shrinks mid-check.
- If `filt_en` falls during CHECK, return to STABLE. This is not counted as a glitch. The bypass rule applies from the next cycle.
- `pwr_s`=0 in any state forces PWR_WAIT on the next edge. That edge also sets `rcv_out`←`RESET_VAL`, clears cnt and produces no pulse. This takes priority over accept.
- `rcv_rise`/`rcv_fall` are registered and asserted in the same cycle as the new `rcv_out` value, for exactly one cycle. They are never both high.

## Timing
- Reset (`rst_l`=0 at an edge) sets: `rcv_out`=`RESET_VAL`, `rcv_rise`=`rcv_fall`=0, `filt_busy`=0, `glitch_cnt`=0, state PWR_WAIT.
- Latency from a `torcvr` change (setup met) to `rcv_out` change is 2 + max(`filt_cnt`,1) edges.
  - In bypass, the latency is 3 edges.
- A pulse on `torcvr` shorter than `filt_cnt` synchronized samples produces no output change.
- Power-up: `rcv_out` is valid 3 edges after `vddo_pwrok` rises.
- Reset asserted mid-CHECK discards the candidate. There is no pulse on reset.

## Configuration
- `BW_IO_IC_FILTER_GLITCH_CNT_EN` defined:
  - `glitch_clr` and `glitch_cnt` ports exist.
  - The counter increments on each glitch and saturates at all-ones.
  - `glitch_clr` has priority over a simultaneous increment; the result is 0.
- Not defined: both ports and the counter are absent. FSM behaviour is identical.

## Structure
- Shared package `bw_io_pkg` holds:
  - the FSM state typedef (PWR_WAIT, STABLE, CHECK);
  - default constants for `FILT_W`, `GLITCH_W` and synchronizer depth 2.
- Sub-module `bw_io_sync2`: a 1-bit 2-flop synchronizer with reset value parameter. It is instantiated twice.

## Test plan
- Reset, then `vddo_pwrok`=1 with `torcvr`=1 → `rcv_out`=0 until the 3rd edge, then 1, with no `rcv_rise`.
- `filt_cnt`=4: `torcvr` 0→1 held → `rcv_out`=1 six edges later, `rcv_rise` high for 1 cycle, `filt_busy` high for 3 cycles.
- `filt_cnt`=4: 2-cycle high pulse on `torcvr` → `rcv_out` stays 0, no pulses, `glitch_cnt`=1.
- `glitch_cnt` at 255 with another glitch → stays 255. Then `glitch_clr` in the same cycle as a glitch → 0.
- `filt_en`=0: `torcvr` toggles every 4 cycles → `rcv_out` follows with 3-edge latency, alternating rise/fall pulses.
- `vddo_pwrok` drops during CHECK with `rcv_out`=1 → `rcv_out`=`RESET_VAL` (0) after the synchronizer, no `rcv_fall`, `filt_busy`=0.

Source files
------------

// File: rtl/bw_io_pkg.sv
// Shared types and default constants for the IO-cell receiver filter controller.
package bw_io_pkg;

  typedef enum logic [1:0] {
    PWR_WAIT,
    STABLE,
    CHECK
  } filt_state_e;

  localparam int FILT_W_DEF   = 8;
  localparam int GLITCH_W_DEF = 8;
  localparam int SYNC_DEPTH   = 2;

endpackage

// File: rtl/bw_io_sync2.sv
// 1-bit two-flop synchronizer with a parameterised reset value.
module bw_io_sync2
  import bw_io_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_l,
  input  logic d,
  output logic q
);

  logic [SYNC_DEPTH-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      sync_q <= {SYNC_DEPTH{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], d};
    end
  end

  assign q = sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/bw_io_ic_filter_ctl.sv
// Receiver deglitch controller: sync, stability qualification, power-good gating.
// Optional glitch counter enabled by defining BW_IO_IC_FILTER_GLITCH_CNT_EN.
module bw_io_ic_filter_ctl
  import bw_io_pkg::*;
#(
  parameter int   FILT_W    = FILT_W_DEF,
  parameter int   GLITCH_W  = GLITCH_W_DEF,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              torcvr,
  input  logic              vddo_pwrok,
  input  logic              filt_en,
  input  logic [FILT_W-1:0] filt_cnt,
  output logic              rcv_out,
  output logic              rcv_rise,
  output logic              rcv_fall,
  output logic              filt_busy
`ifdef BW_IO_IC_FILTER_GLITCH_CNT_EN
  ,
  input  logic                glitch_clr,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  localparam logic [FILT_W:0] ONE = (FILT_W+1)'(1);

  logic              rx_s, pwr_s;
  filt_state_e       state, state_nxt;
  logic [FILT_W-1:0] cnt, cnt_nxt;
  logic [FILT_W:0]   eff_cnt, cnt_inc;
  logic              rcv_out_nxt, rise_nxt, fall_nxt;
  logic              mismatch, bypass;
`ifdef BW_IO_IC_FILTER_GLITCH_CNT_EN
  logic              glitch_inc;
`endif

  bw_io_sync2 #(.RST_VAL(RESET_VAL)) u_sync_rx (
    .clk   (clk),
    .rst_l (rst_l),
    .d     (torcvr),
    .q     (rx_s)
  );

  bw_io_sync2 #(.RST_VAL(1'b0)) u_sync_pwr (
    .clk   (clk),
    .rst_l (rst_l),
    .d     (vddo_pwrok),
    .q     (pwr_s)
  );

  // A programmed count of 0 behaves as 1; one extra bit keeps cnt+1 from wrapping.
  assign eff_cnt  = (filt_cnt == '0) ? ONE : {1'b0, filt_cnt};
  assign cnt_inc  = {1'b0, cnt} + ONE;
  assign mismatch = (rx_s != rcv_out);
  assign bypass   = !filt_en || (eff_cnt <= ONE);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rcv_out_nxt = rcv_out;
    rise_nxt    = 1'b0;
    fall_nxt    = 1'b0;
`ifdef BW_IO_IC_FILTER_GLITCH_CNT_EN
    glitch_inc  = 1'b0;
`endif
    if (!pwr_s) begin
      state_nxt   = PWR_WAIT;
      cnt_nxt     = '0;
      rcv_out_nxt = RESET_VAL;
    end else begin
      unique case (state)
        PWR_WAIT: begin
          state_nxt   = STABLE;
          rcv_out_nxt = rx_s;
        end
        STABLE: begin
          if (mismatch) begin
            if (bypass) begin
              rcv_out_nxt = rx_s;
              rise_nxt    = rx_s;
              fall_nxt    = !rx_s;
            end else begin
              state_nxt = CHECK;
              cnt_nxt   = FILT_W'(1);
            end
          end
        end
        CHECK: begin
          // Dropping filt_en abandons the candidate; bypass takes over next cycle.
          if (!filt_en) begin
            state_nxt = STABLE;
            cnt_nxt   = '0;
          end else if (!mismatch) begin
            state_nxt  = STABLE;
            cnt_nxt    = '0;
`ifdef BW_IO_IC_FILTER_GLITCH_CNT_EN
            glitch_inc = 1'b1;
`endif
          end else if (cnt_inc >= eff_cnt) begin
            state_nxt   = STABLE;
            cnt_nxt     = '0;
            rcv_out_nxt = rx_s;
            rise_nxt    = rx_s;
            fall_nxt    = !rx_s;
          end else begin
            cnt_nxt = cnt_inc[FILT_W-1:0];
          end
        end
        default: begin
          state_nxt   = PWR_WAIT;
          cnt_nxt     = '0;
          rcv_out_nxt = RESET_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state    <= PWR_WAIT;
      cnt      <= '0;
      rcv_out  <= RESET_VAL;
      rcv_rise <= 1'b0;
      rcv_fall <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rcv_out  <= rcv_out_nxt;
      rcv_rise <= rise_nxt;
      rcv_fall <= fall_nxt;
    end
  end

  assign filt_busy = (state == CHECK);

`ifdef BW_IO_IC_FILTER_GLITCH_CNT_EN
  // Saturating glitch counter; clear wins over a coincident increment.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      glitch_cnt <= '0;
    end else if (glitch_clr) begin
      glitch_cnt <= '0;
    end else if (glitch_inc && (glitch_cnt != '1)) begin
      glitch_cnt <= glitch_cnt + GLITCH_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_bw_io_ic_filter_ctl.sv
// Directed, table-driven bench for bw_io_ic_filter_ctl plus multi-cycle corner sequences.
module tb_bw_io_ic_filter_ctl;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       torcvr = 1'b1;
  logic       vddo_pwrok = 1'b0;
  logic       filt_en = 1'b1;
  logic [7:0] filt_cnt = 8'd4;
  logic       rcv_out, rcv_rise, rcv_fall, filt_busy;
`ifdef BW_IO_IC_FILTER_GLITCH_CNT_EN
  logic       glitch_clr = 1'b0;
  logic [7:0] glitch_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected outputs packed as {rcv_out, rcv_rise, rcv_fall, filt_busy}, sampled after the edge.
  typedef struct {
    logic       tor;
    logic       pwr;
    logic       en;
    logic [7:0] fc;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  bw_io_ic_filter_ctl dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .torcvr     (torcvr),
    .vddo_pwrok (vddo_pwrok),
    .filt_en    (filt_en),
    .filt_cnt   (filt_cnt),
    .rcv_out    (rcv_out),
    .rcv_rise   (rcv_rise),
    .rcv_fall   (rcv_fall),
    .filt_busy  (filt_busy)
`ifdef BW_IO_IC_FILTER_GLITCH_CNT_EN
    ,
    .glitch_clr (glitch_clr),
    .glitch_cnt (glitch_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic add(input int n, input logic tor, input logic pwr, input logic en,
                     input logic [7:0] fc, input logic [3:0] exp);
    vec_t v;
    v = '{tor: tor, pwr: pwr, en: en, fc: fc, exp: exp};
    repeat (n) vecs.push_back(v);
  endtask

  task automatic step(input logic tor, input logic pwr, input logic en, input logic [7:0] fc);
    @(negedge clk);
    torcvr     = tor;
    vddo_pwrok = pwr;
    filt_en    = en;
    filt_cnt   = fc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] outs();
    return {rcv_out, rcv_rise, rcv_fall, filt_busy};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-up with torcvr high: output loads on the 3rd edge, no pulse.
    add(2, 1, 1, 1, 8'd4, 4'b0000);
    add(2, 1, 1, 1, 8'd4, 4'b1000);
    // filt_cnt=4 falling edge: accept 6 edges after the change.
    add(2, 0, 1, 1, 8'd4, 4'b1000);
    add(3, 0, 1, 1, 8'd4, 4'b1001);
    add(1, 0, 1, 1, 8'd4, 4'b0010);
    add(1, 0, 1, 1, 8'd4, 4'b0000);
    // 2-cycle high pulse is rejected as a glitch.
    add(2, 1, 1, 1, 8'd4, 4'b0000);
    add(2, 0, 1, 1, 8'd4, 4'b0001);
    add(2, 0, 1, 1, 8'd4, 4'b0000);
    // filt_cnt=4 rising edge: busy for 3 cycles, one rise pulse.
    add(2, 1, 1, 1, 8'd4, 4'b0000);
    add(3, 1, 1, 1, 8'd4, 4'b0001);
    add(1, 1, 1, 1, 8'd4, 4'b1100);
    add(1, 1, 1, 1, 8'd4, 4'b1000);
    // Bypass: toggle every 4 cycles, 3-edge latency.
    add(2, 0, 1, 0, 8'd4, 4'b1000);
    add(1, 0, 1, 0, 8'd4, 4'b0010);
    add(1, 0, 1, 0, 8'd4, 4'b0000);
    add(2, 1, 1, 0, 8'd4, 4'b0000);
    add(1, 1, 1, 0, 8'd4, 4'b1100);
    add(1, 1, 1, 0, 8'd4, 4'b1000);
    add(2, 0, 1, 0, 8'd4, 4'b1000);
    add(1, 0, 1, 0, 8'd4, 4'b0010);
    add(1, 0, 1, 0, 8'd4, 4'b0000);
    // filt_cnt=0 behaves as 1: no CHECK, 3-edge latency.
    add(2, 1, 1, 1, 8'd0, 4'b0000);
    add(1, 1, 1, 1, 8'd0, 4'b1100);
    add(1, 1, 1, 1, 8'd0, 4'b1000);
    // filt_cnt=2: one CHECK cycle, 4-edge latency.
    add(2, 0, 1, 1, 8'd2, 4'b1000);
    add(1, 0, 1, 1, 8'd2, 4'b1001);
    add(1, 0, 1, 1, 8'd2, 4'b0010);
    // filt_cnt shrinks from 8 to 2 mid-check: immediate accept.
    add(2, 1, 1, 1, 8'd8, 4'b0000);
    add(2, 1, 1, 1, 8'd8, 4'b0001);
    add(1, 1, 1, 1, 8'd2, 4'b1100);
    // filt_en drops during CHECK: back to STABLE, then bypass accepts.
    add(2, 0, 1, 1, 8'd4, 4'b1000);
    add(1, 0, 1, 1, 8'd4, 4'b1001);
    add(1, 0, 1, 0, 8'd4, 4'b1000);
    add(1, 0, 1, 0, 8'd4, 4'b0010);
    add(1, 0, 1, 0, 8'd4, 4'b0000);

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", outs(), 4'b0000);
`ifdef BW_IO_IC_FILTER_GLITCH_CNT_EN
    check("reset_glitch_cnt", glitch_cnt, 0);
`endif
    rst_l = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].tor, vecs[i].pwr, vecs[i].en, vecs[i].fc);
      check($sformatf("vec%0d", i + 1), outs(), vecs[i].exp);
    end
`ifdef BW_IO_IC_FILTER_GLITCH_CNT_EN
    check("glitch_cnt_after_table", glitch_cnt, 1);
`endif

    // Power drops during CHECK with rcv_out=1.
    repeat (2) step(1, 1, 1, 8'd0);
    step(1, 1, 1, 8'd0);
    check("pwr_seq_rise", outs(), 4'b1100);
    step(1, 1, 1, 8'd8);
    step(0, 1, 1, 8'd8);
    step(0, 1, 1, 8'd8);
    step(0, 1, 1, 8'd8);
    check("pwr_seq_check", outs(), 4'b1001);
    step(0, 0, 1, 8'd8);
    check("pwr_drop_sync1", outs(), 4'b1001);
    step(0, 0, 1, 8'd8);
    check("pwr_drop_sync2", outs(), 4'b1001);
    step(0, 0, 1, 8'd8);
    check("pwr_drop_forced", outs(), 4'b0000);
    step(0, 0, 1, 8'd8);
    check("pwr_drop_hold", outs(), 4'b0000);
    // Power returns with torcvr high: load on the 3rd edge without a pulse.
    step(1, 1, 1, 8'd8);
    step(1, 1, 1, 8'd8);
    check("repower_wait", outs(), 4'b0000);
    step(1, 1, 1, 8'd8);
    check("repower_load", outs(), 4'b1000);

    // Reset in the middle of a CHECK discards the candidate with no pulse.
    repeat (3) step(0, 1, 1, 8'd8);
    check("pre_reset_check", outs(), 4'b1001);
    @(negedge clk);
    rst_l = 1'b0;
    @(posedge clk);
    #1;
    check("reset_mid_check", outs(), 4'b0000);
`ifdef BW_IO_IC_FILTER_GLITCH_CNT_EN
    check("reset_mid_check_glitch_cnt", glitch_cnt, 0);
`endif
    @(negedge clk);
    rst_l = 1'b1;
    repeat (5) step(0, 1, 1, 8'd4);
    check("post_reset_stable", outs(), 4'b0000);

`ifdef BW_IO_IC_FILTER_GLITCH_CNT_EN
    // Saturation: 255 glitches reach all-ones, one more stays there.
    for (int g = 0; g < 255; g++) begin
      step(1, 1, 1, 8'd4);
      repeat (4) step(0, 1, 1, 8'd4);
    end
    check("glitch_cnt_255", glitch_cnt, 255);
    step(1, 1, 1, 8'd4);
    repeat (4) step(0, 1, 1, 8'd4);
    check("glitch_cnt_saturated", glitch_cnt, 255);
    check("glitch_out_quiet", outs(), 4'b0000);
    // Clear coinciding with a glitch edge yields 0.
    step(1, 1, 1, 8'd4);
    step(0, 1, 1, 8'd4);
    step(0, 1, 1, 8'd4);
    check("glitch_pre_clr_busy", outs(), 4'b0001);
    @(negedge clk);
    torcvr     = 1'b0;
    glitch_clr = 1'b1;
    @(posedge clk);
    #1;
    check("glitch_clr_priority", glitch_cnt, 0);
    @(negedge clk);
    glitch_clr = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
